// File: rtl/pipeline_sequencer_if.sv
// pipeline_sequencer_if: control bundle between the pipeline sequencer and the core stages.
// Perf counter signals exist only when SEQ_PERF_COUNTERS_EN is defined.
interface pipeline_sequencer_if #(
    parameter int PC_W = 32
);
    logic            branch_in_decode;
    logic            load_use_hazard;
    logic            jump_taken;
    logic [PC_W-1:0] jump_dest;
    logic [PC_W-1:0] exec_pc;
    logic            halt_req;
    logic [PC_W-1:0] pc;
    logic            fetch_en;
    logic            decoder_enabled;
    logic            executer_enabled;
    logic            writer_enabled;
    logic            flush;
    logic            completed;
    logic [2:0]      state;
`ifdef SEQ_PERF_COUNTERS_EN
    logic [31:0]     cycle_cnt;
    logic [31:0]     branch_cnt;
    logic [31:0]     stall_cnt;
`endif

    modport master (
        input  branch_in_decode, load_use_hazard, jump_taken, jump_dest, exec_pc, halt_req,
        output pc, fetch_en, decoder_enabled, executer_enabled, writer_enabled, flush, completed, state
`ifdef SEQ_PERF_COUNTERS_EN
        , output cycle_cnt, branch_cnt, stall_cnt
`endif
    );

    modport slave (
        output branch_in_decode, load_use_hazard, jump_taken, jump_dest, exec_pc, halt_req,
        input  pc, fetch_en, decoder_enabled, executer_enabled, writer_enabled, flush, completed, state
`ifdef SEQ_PERF_COUNTERS_EN
        , input cycle_cnt, branch_cnt, stall_cnt
`endif
    );
endinterface

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: fetch PC owner and stage-enable FSM for the 3-stage core (branch, load-use, halt, completion).
// Optional perf counters (cycle/branch/stall) are built when SEQ_PERF_COUNTERS_EN is defined.
module pipeline_sequencer #(
    parameter int              PC_W         = 32,
    parameter logic [PC_W-1:0] RESET_PC     = '0,
    parameter int              FINAL_PC     = 35,
    parameter int              LOAD_STALL_N = 1
) (
    input logic                  clk,
    input logic                  rst,
    pipeline_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        RUN      = 3'd0,
        BR_EXEC  = 3'd1,
        BR_WRITE = 3'd2,
        LD_STALL = 3'd3,
        HALTED   = 3'd4,
        DONE     = 3'd5
    } state_e;

    localparam logic [PC_W-1:0] DONE_PC = PC_W'(FINAL_PC + 1);
    localparam logic [PC_W-1:0] ONE     = PC_W'(1);
    localparam logic [2:0]      BUB_INIT = 3'(LOAD_STALL_N - 1);

    // en bits, msb first: fetch, decoder, executer, writer
    localparam logic [3:0] EN_ALL    = 4'b1111;
    localparam logic [3:0] EN_NO_DEC = 4'b1011;
    localparam logic [3:0] EN_LOAD   = 4'b0011;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [3:0]      en_q, en_d;
    logic            flush_q, flush_d;
    logic            completed_q, completed_d;
    logic [2:0]      bub_q, bub_d;

    // next state: completion preempts everything; the hazard priority only applies in RUN
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        en_d        = en_q;
        flush_d     = 1'b0;
        completed_d = completed_q;
        bub_d       = bub_q;
        if (state_q != DONE && bus.exec_pc == DONE_PC) begin
            state_d     = DONE;
            completed_d = 1'b1;
            en_d        = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (bus.branch_in_decode) begin
                        state_d = BR_EXEC;
                        en_d    = EN_NO_DEC;
                    end else if (bus.load_use_hazard) begin
                        state_d = LD_STALL;
                        en_d    = EN_LOAD;
                        bub_d   = BUB_INIT;
                    end else if (bus.halt_req) begin
                        state_d = HALTED;
                        en_d    = '0;
                    end else begin
                        pc_d = pc_q + ONE;
                        en_d = EN_ALL;
                    end
                end
                BR_EXEC: begin
                    state_d = BR_WRITE;
                    pc_d    = bus.jump_taken ? bus.jump_dest - ONE : pc_q;
                    flush_d = bus.jump_taken;
                end
                BR_WRITE: begin
                    state_d = RUN;
                    pc_d    = pc_q + ONE;
                    en_d    = EN_ALL;
                end
                LD_STALL: begin
                    state_d = (bub_q == 3'd0) ? RUN : LD_STALL;
                    pc_d    = (bub_q == 3'd0) ? pc_q + ONE : pc_q;
                    en_d    = (bub_q == 3'd0) ? EN_ALL : en_q;
                    bub_d   = (bub_q == 3'd0) ? bub_q : bub_q - 3'd1;
                end
                HALTED: begin
                    state_d = bus.halt_req ? HALTED : RUN;
                    en_d    = bus.halt_req ? en_q : EN_ALL;
                end
                DONE: state_d = DONE;
                default: begin
                    state_d = RUN;
                    en_d    = EN_ALL;
                end
            endcase
        end
    end

    // state and registered outputs, asynchronously returned to the run state on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            pc_q        <= RESET_PC;
            en_q        <= EN_ALL;
            flush_q     <= 1'b0;
            completed_q <= 1'b0;
            bub_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            en_q        <= en_d;
            flush_q     <= flush_d;
            completed_q <= completed_d;
            bub_q       <= bub_d;
        end
    end

    assign bus.pc               = pc_q;
    assign bus.fetch_en         = en_q[3];
    assign bus.decoder_enabled  = en_q[2];
    assign bus.executer_enabled = en_q[1];
    assign bus.writer_enabled   = en_q[0];
    assign bus.flush            = flush_q;
    assign bus.completed        = completed_q;
    assign bus.state            = state_q;

`ifdef SEQ_PERF_COUNTERS_EN
    logic [31:0] cyc_q, cyc_d, br_q, br_d, stl_q, stl_d;
    logic        stalled;

    // saturating counts of live cycles, branch entries and non-RUN stall cycles
    always_comb begin
        stalled = state_q inside {BR_EXEC, BR_WRITE, LD_STALL, HALTED};
        cyc_d   = (state_q != DONE && cyc_q != '1) ? cyc_q + 32'd1 : cyc_q;
        br_d    = (state_q == RUN && state_d == BR_EXEC && br_q != '1) ? br_q + 32'd1 : br_q;
        stl_d   = (stalled && stl_q != '1) ? stl_q + 32'd1 : stl_q;
    end

    // perf counter registers, cleared on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q <= '0;
            br_q  <= '0;
            stl_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            br_q  <= br_d;
            stl_q <= stl_d;
        end
    end

    assign bus.cycle_cnt  = cyc_q;
    assign bus.branch_cnt = br_q;
    assign bus.stall_cnt  = stl_q;
`endif
endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb_pipeline_sequencer: randomized operation-level scoreboard bench for pipeline_sequencer.
module tb_pipeline_sequencer;
    localparam int PC_W = 32;
    localparam int LSN  = 2;
    localparam int FIN  = 35;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  en;
        logic        fl;
        logic        co;
        logic [2:0]  st;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst;
    frame_t      sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] m_pc;

    always #5 clk = ~clk;

    pipeline_sequencer_if #(.PC_W(PC_W)) bus ();

    pipeline_sequencer #(
        .PC_W(PC_W), .RESET_PC(32'd0), .FINAL_PC(FIN), .LOAD_STALL_N(LSN)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    function automatic frame_t fr(input logic [31:0] p, input logic [3:0] en, input logic fl, input logic co,
                                  input logic [2:0] st);
        return {p, en, fl, co, st};
    endfunction

    function automatic logic [31:0] safe_epc();
        logic [31:0] v;
        do v = $urandom; while (v == FIN + 1);
        return v;
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    task automatic check(input frame_t e, input string nm);
        frame_t a;
        a = {bus.pc, bus.fetch_en, bus.decoder_enabled, bus.executer_enabled, bus.writer_enabled,
             bus.flush, bus.completed, bus.state};
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got pc=%h en=%b flush=%b completed=%b state=%0d, expected pc=%h en=%b flush=%b completed=%b state=%0d",
                     nm, a.pc, a.en, a.fl, a.co, a.st, e.pc, e.en, e.fl, e.co, e.st);
        end
    endtask

    // monitor: every frame the DUT shows after an edge is matched against the scoreboard
    always @(negedge clk) begin
        if (sb.size() != 0) check(sb.pop_front(), "frame");
    end

    task automatic drive(input logic b, input logic l, input logic jt, input logic [31:0] jd, input logic h,
                         input logic [31:0] e);
        bus.branch_in_decode = b;
        bus.load_use_hazard  = l;
        bus.jump_taken       = jt;
        bus.jump_dest        = jd;
        bus.halt_req         = h;
        bus.exec_pc          = e;
    endtask

    task automatic step(input frame_t e);
        @(posedge clk);
        sb.push_back(e);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check(fr(32'd0, 4'hF, 1'b0, 1'b0, 3'd0), "async_reset");
        drive(0, 0, 0, 32'd0, 0, 32'd0);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        m_pc = 32'd0;
    endtask

    task automatic op_run();
        drive(0, 0, rb(), $urandom, 0, safe_epc());
        m_pc = m_pc + 1;
        step(fr(m_pc, 4'hF, 1'b0, 1'b0, 3'd0));
    endtask

    // a branch costs exactly two frames, then the PC moves on from the resolved target
    task automatic op_branch(input logic t, input logic [31:0] d, input logic luh, input logic hr);
        drive(1, luh, rb(), $urandom, hr, safe_epc());
        step(fr(m_pc, 4'b1011, 1'b0, 1'b0, 3'd1));
        drive(rb(), rb(), t, d, rb(), safe_epc());
        if (t) m_pc = d - 1;
        step(fr(m_pc, 4'b1011, t, 1'b0, 3'd2));
        drive(rb(), luh, rb(), $urandom, rb(), safe_epc());
        m_pc = m_pc + 1;
        step(fr(m_pc, 4'hF, 1'b0, 1'b0, 3'd0));
    endtask

    task automatic op_load();
        drive(0, 1, rb(), $urandom, rb(), safe_epc());
        for (int i = 0; i < LSN; i++) begin
            step(fr(m_pc, 4'b0011, 1'b0, 1'b0, 3'd3));
            drive(rb(), rb(), rb(), $urandom, rb(), safe_epc());
        end
        m_pc = m_pc + 1;
        step(fr(m_pc, 4'hF, 1'b0, 1'b0, 3'd0));
    endtask

    task automatic op_halt(input int k);
        drive(0, 0, rb(), $urandom, 1, safe_epc());
        step(fr(m_pc, 4'h0, 1'b0, 1'b0, 3'd4));
        for (int i = 1; i < k; i++) begin
            drive(rb(), rb(), rb(), $urandom, 1, safe_epc());
            step(fr(m_pc, 4'h0, 1'b0, 1'b0, 3'd4));
        end
        drive(rb(), rb(), rb(), $urandom, 0, safe_epc());
        step(fr(m_pc, 4'hF, 1'b0, 1'b0, 3'd0));
    endtask

    task automatic hold_done(input int n);
        for (int i = 0; i < n; i++) begin
            drive(rb(), rb(), rb(), $urandom, rb(), $urandom);
            step(fr(m_pc, 4'h0, 1'b0, 1'b1, 3'd5));
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 32'd0, 0, 32'd0);
        #1;
        check(fr(32'd0, 4'hF, 1'b0, 1'b0, 3'd0), "reset_state");
        @(posedge clk);
        #1;
        rst  = 1'b0;
        m_pc = 32'd0;
        // load-use at PC=7 holds for two frames, then 8
        repeat (7) op_run();
        op_load();
        op_run();
        // PC=9: taken to 12 gives 9,9,11,12; not taken gives 9,9,9,10 pattern
        op_branch(1'b1, 32'd12, 1'b0, 1'b0);
        op_branch(1'b0, $urandom, 1'b0, 1'b0);
        // taken to 0 wraps to all-ones, then back to 0
        op_branch(1'b1, 32'd0, 1'b0, 1'b0);
        // simultaneous branch and load: branch first, load honoured afterwards
        op_branch(1'b1, 32'd20, 1'b1, 1'b1);
        op_load();
        op_halt(3);
        op_run();
        // reset in the middle of a branch leaves no residue
        drive(1, 0, 0, 32'd0, 0, safe_epc());
        step(fr(m_pc, 4'b1011, 1'b0, 1'b0, 3'd1));
        do_reset();
        op_run();
        op_run();
        for (int n = 0; n < 300; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 5) op_run();
            else if (r < 7) op_branch(rb(), ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom, rb(), rb());
            else if (r < 8) op_load();
            else op_halt($urandom_range(1, 3));
        end
        // completion during BR_EXEC preempts the branch and ignores halt
        drive(1, 0, 0, 32'd0, 0, safe_epc());
        step(fr(m_pc, 4'b1011, 1'b0, 1'b0, 3'd1));
        drive(0, 0, 1, 32'd5, 1, 32'(FIN + 1));
        step(fr(m_pc, 4'h0, 1'b0, 1'b1, 3'd5));
        hold_done(4);
        do_reset();
        repeat (3) op_run();
        // completion while halted and while load-stalled
        drive(0, 0, 0, 32'd0, 1, safe_epc());
        step(fr(m_pc, 4'h0, 1'b0, 1'b0, 3'd4));
        drive(0, 0, 0, 32'd0, 1, 32'(FIN + 1));
        step(fr(m_pc, 4'h0, 1'b0, 1'b1, 3'd5));
        hold_done(3);
        do_reset();
        op_run();
        drive(0, 1, 0, 32'd0, 0, safe_epc());
        step(fr(m_pc, 4'b0011, 1'b0, 1'b0, 3'd3));
        drive(0, 0, 0, 32'd0, 0, 32'(FIN + 1));
        step(fr(m_pc, 4'h0, 1'b0, 1'b1, 3'd5));
        hold_done(3);
        @(negedge clk);
        #1;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending frames, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
